// File: rtl/sodor3_commit_checker.sv
// Retirement checker: buffers core and model writebacks in per-side FIFOs, compares heads in order,
// and freezes on the first divergence or overflow so the failing pair stays visible.
module sodor3_commit_checker #(
  parameter int DEPTH     = 8,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     core_wb_valid,
  input  logic [4:0]               core_wb_rd,
  input  logic [31:0]              core_wb_data,
  input  logic                     model_wb_valid,
  input  logic [4:0]               model_wb_rd,
  input  logic [31:0]              model_wb_data,
  output logic                     mismatch,
  output logic                     overflow,
  output logic [4:0]               fail_rd_core,
  output logic [4:0]               fail_rd_model,
  output logic [31:0]              fail_data_core,
  output logic [31:0]              fail_data_model,
  output logic [31:0]              compare_count,
  output logic [$clog2(DEPTH):0]   core_pending,
  output logic [$clog2(DEPTH):0]   model_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_FAIL  = 1'b1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t core_mem_q  [DEPTH];
  wb_t model_mem_q [DEPTH];

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] core_wr_q, core_wr_d, core_rd_q, core_rd_d;
  logic [AW-1:0] model_wr_q, model_wr_d, model_rd_q, model_rd_d;
  logic [AW:0]   core_cnt_q, core_cnt_d, model_cnt_q, model_cnt_d;
  logic          mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic [4:0]    fail_rd_core_q, fail_rd_core_d, fail_rd_model_q, fail_rd_model_d;
  logic [31:0]   fail_data_core_q, fail_data_core_d, fail_data_model_q, fail_data_model_d;
  logic [31:0]   count_q, count_d;

  logic core_push, model_push, pop, core_acc, model_acc, core_drop, model_drop, heads_equal;
  wb_t  core_head, model_head;

  always_comb begin
    core_push   = core_wb_valid  && !(FILTER_X0 && (core_wb_rd  == 5'd0));
    model_push  = model_wb_valid && !(FILTER_X0 && (model_wb_rd == 5'd0));
    pop         = (state_q == ST_RUN) && (core_cnt_q != '0) && (model_cnt_q != '0);
    // A full FIFO still takes a push when it frees a slot at the same edge.
    core_acc    = core_push  && ((core_cnt_q  != CNT_FULL) || pop);
    model_acc   = model_push && ((model_cnt_q != CNT_FULL) || pop);
    core_drop   = core_push  && !core_acc;
    model_drop  = model_push && !model_acc;
    core_head   = core_mem_q[core_rd_q];
    model_head  = model_mem_q[model_rd_q];
    heads_equal = (core_head.rd == model_head.rd) && (core_head.data == model_head.data);

    state_d           = state_q;
    mismatch_d        = mismatch_q;
    overflow_d        = overflow_q;
    fail_rd_core_d    = fail_rd_core_q;
    fail_rd_model_d   = fail_rd_model_q;
    fail_data_core_d  = fail_data_core_q;
    fail_data_model_d = fail_data_model_q;
    count_d           = count_q;
    core_wr_d         = core_acc  ? core_wr_q  + PTR_ONE : core_wr_q;
    model_wr_d        = model_acc ? model_wr_q + PTR_ONE : model_wr_q;
    core_rd_d         = pop ? core_rd_q  + PTR_ONE : core_rd_q;
    model_rd_d        = pop ? model_rd_q + PTR_ONE : model_rd_q;

    unique case ({core_acc, pop})
      2'b10:   core_cnt_d = core_cnt_q + CNT_ONE;
      2'b01:   core_cnt_d = core_cnt_q - CNT_ONE;
      default: core_cnt_d = core_cnt_q;
    endcase
    unique case ({model_acc, pop})
      2'b10:   model_cnt_d = model_cnt_q + CNT_ONE;
      2'b01:   model_cnt_d = model_cnt_q - CNT_ONE;
      default: model_cnt_d = model_cnt_q;
    endcase

    if (state_q == ST_RUN) begin
      if (core_drop || model_drop) begin
        overflow_d = 1'b1;
        state_d    = ST_FAIL;
      end
      if (pop && heads_equal) begin
        count_d = count_q + 32'd1;
      end else if (pop) begin
        mismatch_d        = 1'b1;
        fail_rd_core_d    = core_head.rd;
        fail_rd_model_d   = model_head.rd;
        fail_data_core_d  = core_head.data;
        fail_data_model_d = model_head.data;
        state_d           = ST_FAIL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (core_acc)  core_mem_q[core_wr_q]   <= '{rd: core_wb_rd,  data: core_wb_data};
    if (model_acc) model_mem_q[model_wr_q] <= '{rd: model_wb_rd, data: model_wb_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_RUN;
      core_wr_q         <= '0;
      core_rd_q         <= '0;
      model_wr_q        <= '0;
      model_rd_q        <= '0;
      core_cnt_q        <= '0;
      model_cnt_q       <= '0;
      mismatch_q        <= 1'b0;
      overflow_q        <= 1'b0;
      fail_rd_core_q    <= '0;
      fail_rd_model_q   <= '0;
      fail_data_core_q  <= '0;
      fail_data_model_q <= '0;
      count_q           <= '0;
    end else begin
      state_q           <= state_d;
      core_wr_q         <= core_wr_d;
      core_rd_q         <= core_rd_d;
      model_wr_q        <= model_wr_d;
      model_rd_q        <= model_rd_d;
      core_cnt_q        <= core_cnt_d;
      model_cnt_q       <= model_cnt_d;
      mismatch_q        <= mismatch_d;
      overflow_q        <= overflow_d;
      fail_rd_core_q    <= fail_rd_core_d;
      fail_rd_model_q   <= fail_rd_model_d;
      fail_data_core_q  <= fail_data_core_d;
      fail_data_model_q <= fail_data_model_d;
      count_q           <= count_d;
    end
  end

  assign mismatch        = mismatch_q;
  assign overflow        = overflow_q;
  assign fail_rd_core    = fail_rd_core_q;
  assign fail_rd_model   = fail_rd_model_q;
  assign fail_data_core  = fail_data_core_q;
  assign fail_data_model = fail_data_model_q;
  assign compare_count   = count_q;
  assign core_pending    = core_cnt_q;
  assign model_pending   = model_cnt_q;

endmodule
